sha1_work_scheduler: RTL and testbench
======================================

// Module: sha1_work_scheduler
// PURPOSE
//  Downstream consumer of the JTAG work registers; runs in the rx_hash_clk domain. Latches each new job and
//  issues one {fixed_data, nonce} candidate per cycle to the pipelined SHA-1 core, starting at start_nonce.
//  Matches returned digests against target_hash and reports the first matching nonce back to the JTAG block.
//  Tracks in-flight candidates so results belonging to a superseded job are discarded.
// PARAMETERS
//  NONCE_W     60   nonce width
//  FIXED_W     56   fixed message data width
//  HASH_W      160  digest / target width
//  PIPE_DEPTH  82   cycles from core_valid/core_data issue to matching core_hash_in (>=1)
// PORTS
//  rx_hash_clk            in   1        hash clock; all state on rising edge
//  jt_reset               in   1        reset, asynchronous, active-high
//  tx_new_work            in   1        1-cycle pulse: job fields below are stable and new
//  tx_fixed_data          in   FIXED_W  job fixed data
//  tx_target_hash         in   HASH_W   job target digest
//  tx_start_nonce         in   NONCE_W  first nonce of job
//  core_valid             out  1        candidate issued this cycle
//  core_data              out  FIXED_W+NONCE_W  {fixed, nonce} candidate
//  core_hash_in           in   HASH_W   digest of candidate issued PIPE_DEPTH cycles earlier
//  rx_golden_nonce_found  out  1        sticky: a match was found for the current job
//  rx_golden_nonce        out  NONCE_W  first matching nonce of current job
//  busy                   out  1        state RUN or DRAIN
//  exhausted              out  1        state DONE: whole nonce space issued and drained, no restart
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; core_valid, core_data, found, golden, busy, exhausted = 0;
//    delay line valid bits and epoch cleared; drain counter 0.
//  - Job latch: tx_new_work in any state copies fixed/target into job regs, nonce_ctr<=tx_start_nonce,
//    toggles epoch bit, clears found/golden/exhausted, state<=RUN. Takes priority over every other event.
//  - States: IDLE --new_work--> RUN; RUN --issued nonce==all-ones--> DRAIN; DRAIN --counter==PIPE_DEPTH+1-->
//    DONE; DONE --new_work--> RUN. new_work from RUN/DRAIN restarts RUN.
//  - RUN: each cycle registered core_valid=1, core_data={job_fixed, nonce_ctr}, nonce_ctr+=1 (mod 2^NONCE_W).
//    First issue is the cycle after tx_new_work. Nonce all-ones is issued, then no wrap: go DRAIN.
//  - DRAIN/IDLE/DONE: core_valid=0 (core_data holds last value).
//  - Tracking: shift register depth PIPE_DEPTH of {valid, epoch, nonce} fed in parallel with core issue;
//    its tail is aligned with core_hash_in.
//  - Compare: hit = tail.valid & tail.epoch==epoch & core_hash_in==job_target (full HASH_W equality),
//    registered; found/golden update one cycle after hit => report latency PIPE_DEPTH+1 from issue.
//  - Only first hit per job sets golden; later hits ignored while found=1. found stays 1 until new_work/reset.
//  - Stale results (epoch mismatch) never raise found. Hit in same cycle as new_work: new_work wins, found=0.
//  - Outputs found/golden change together in one edge (consumer double-samples them as a pair).
// TESTING (bench: PIPE_DEPTH=4, core model = registered delay of 4 with hash f(nonce))
//  - jt_reset pulsed mid-RUN -> all outputs 0 immediately (before next edge), state IDLE, no issue until new_work.
//  - start=0x100, target=f(0x105) -> core_data nonces 0x100,0x101,...; found=1, golden=0x105 exactly
//    5 cycles after 0x105 issued; both held through 100 further cycles.
//  - target matched by 0x105 and 0x107 (f collides) -> golden stays 0x105.
//  - start=0xFFF_FFFF_FFFF_FFFD -> issues ..FD,..FE,..FF then core_valid=0, busy=1 for 5 cycles, then
//    exhausted=1, busy=0; no nonce 0 issued.
//  - hit for 0x105 in flight, new_work (start=0x200) 2 cycles before its report -> found stays 0, issue resumes at 0x200.
//  - new_work on same edge a hit registers -> found=0, golden=0 after edge; new job proceeds normally.

Source files
------------

// File: rtl/sha1_work_scheduler.sv
// Feeds one {fixed, nonce} candidate per cycle into a pipelined SHA-1 core and tags each issue with an epoch so
// that digests from a superseded job are ignored; golden nonce reported PIPE_DEPTH+1 cycles after issue, no backpressure.
module sha1_work_scheduler #(
   parameter int NONCE_W    = 60,
   parameter int FIXED_W    = 56,
   parameter int HASH_W     = 160,
   parameter int PIPE_DEPTH = 82
) (
   input  logic                       rx_hash_clk,
   input  logic                       jt_reset,
   input  logic                       tx_new_work,
   input  logic [FIXED_W-1:0]         tx_fixed_data,
   input  logic [HASH_W-1:0]          tx_target_hash,
   input  logic [NONCE_W-1:0]         tx_start_nonce,
   output logic                       core_valid,
   output logic [FIXED_W+NONCE_W-1:0] core_data,
   input  logic [HASH_W-1:0]          core_hash_in,
   output logic                       rx_golden_nonce_found,
   output logic [NONCE_W-1:0]         rx_golden_nonce,
   output logic                       busy,
   output logic                       exhausted
);

   localparam int CNT_W = $clog2(PIPE_DEPTH + 2) + 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic [FIXED_W-1:0]   job_fixed;
   logic [HASH_W-1:0]    job_target;
   logic [NONCE_W-1:0]   nonce_ctr;
   logic                 epoch;
   logic [CNT_W-1:0]     drain_cnt;

   logic                 trk_vld   [PIPE_DEPTH];
   logic                 trk_epoch [PIPE_DEPTH];
   logic [NONCE_W-1:0]   trk_nonce [PIPE_DEPTH];

   logic                 hit;

   always_ff @(posedge rx_hash_clk or posedge jt_reset) begin
      if (jt_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tx_new_work) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN:     if (nonce_ctr == '1) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   assign busy      = (state == RUN) || (state == DRAIN);
   assign exhausted = (state == DONE);

   // Job registers and candidate issue; the latch cycle itself never issues.
   always_ff @(posedge rx_hash_clk or posedge jt_reset) begin
      if (jt_reset) begin
         job_fixed  <= '0;
         job_target <= '0;
         nonce_ctr  <= '0;
         epoch      <= 1'b0;
         drain_cnt  <= '0;
         core_valid <= 1'b0;
         core_data  <= '0;
      end else begin
         core_valid <= 1'b0;
         if (tx_new_work) begin
            job_fixed  <= tx_fixed_data;
            job_target <= tx_target_hash;
            nonce_ctr  <= tx_start_nonce;
            epoch      <= ~epoch;
            drain_cnt  <= '0;
         end else if (state == RUN) begin
            core_valid <= 1'b1;
            core_data  <= {job_fixed, nonce_ctr};
            nonce_ctr  <= nonce_ctr + NONCE_W'(1);
            drain_cnt  <= '0;
         end else if (state == DRAIN) begin
            drain_cnt  <= drain_cnt + CNT_W'(1);
         end
      end
   end

   // The core_data register acts as stage zero, so the tail lines up with core_hash_in.
   always_ff @(posedge rx_hash_clk or posedge jt_reset) begin
      if (jt_reset) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            trk_vld[i]   <= 1'b0;
            trk_epoch[i] <= 1'b0;
            trk_nonce[i] <= '0;
         end
      end else begin
         trk_vld[0]   <= core_valid;
         trk_epoch[0] <= epoch;
         trk_nonce[0] <= core_data[NONCE_W-1:0];
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            trk_vld[i]   <= trk_vld[i-1];
            trk_epoch[i] <= trk_epoch[i-1];
            trk_nonce[i] <= trk_nonce[i-1];
         end
      end
   end

   assign hit = trk_vld[PIPE_DEPTH-1]
             && (trk_epoch[PIPE_DEPTH-1] == epoch)
             && (core_hash_in == job_target);

   always_ff @(posedge rx_hash_clk or posedge jt_reset) begin
      if (jt_reset) begin
         rx_golden_nonce_found <= 1'b0;
         rx_golden_nonce       <= '0;
      end else if (tx_new_work) begin
         rx_golden_nonce_found <= 1'b0;
         rx_golden_nonce       <= '0;
      end else if (hit && !rx_golden_nonce_found) begin
         rx_golden_nonce_found <= 1'b1;
         rx_golden_nonce       <= trk_nonce[PIPE_DEPTH-1];
      end
   end

endmodule

// File: tb/tb_sha1_work_scheduler.sv
// Scoreboard bench: jobs push expected candidates, golden nonces and exhaustion events; a negedge monitor pops and compares.
module tb_sha1_work_scheduler;

   localparam int NW = 60;
   localparam int FW = 56;
   localparam int HW = 160;
   localparam int PD = 4;

   logic            clk;
   logic            jt_reset;
   logic            tx_new_work;
   logic [FW-1:0]   tx_fixed_data;
   logic [HW-1:0]   tx_target_hash;
   logic [NW-1:0]   tx_start_nonce;
   logic            core_valid;
   logic [FW+NW-1:0] core_data;
   logic [HW-1:0]   core_hash_in;
   logic            found;
   logic [NW-1:0]   golden;
   logic            busy;
   logic            exhausted;

   sha1_work_scheduler #(.NONCE_W(NW), .FIXED_W(FW), .HASH_W(HW), .PIPE_DEPTH(PD)) dut (
      .rx_hash_clk           (clk),
      .jt_reset              (jt_reset),
      .tx_new_work           (tx_new_work),
      .tx_fixed_data         (tx_fixed_data),
      .tx_target_hash        (tx_target_hash),
      .tx_start_nonce        (tx_start_nonce),
      .core_valid            (core_valid),
      .core_data             (core_data),
      .core_hash_in          (core_hash_in),
      .rx_golden_nonce_found (found),
      .rx_golden_nonce       (golden),
      .busy                  (busy),
      .exhausted             (exhausted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   logic [FW+NW-1:0] cand_q [$];
   logic [NW-1:0]    gold_q [$];
   bit               exh_q  [$];
   int               issue_cyc [logic [NW-1:0]];
   int               last_issue_cyc = 0;

   // Toy digest; 0x107 deliberately collides with 0x105.
   function automatic logic [HW-1:0] f(input logic [NW-1:0] n);
      logic [63:0] a, b, m;
      m = {4'h0, (n == 60'h107) ? 60'h105 : n};
      a = (m + 64'h0123_4567_89AB_CDEF) * 64'h9E37_79B9_7F4A_7C15;
      b = (a ^ (a >> 29)) * 64'hBF58_476D_1CE4_E5B9;
      return {a, b, a[31:0] ^ b[63:32]};
   endfunction

   task automatic check(input bit ok, input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Core model: digest of core_data appears PD cycles after issue.
   logic [HW-1:0] hpipe [PD];
   initial for (int i = 0; i < PD; i++) hpipe[i] = '0;
   always @(posedge clk) begin
      hpipe[0] <= f(core_data[NW-1:0]);
      for (int i = 1; i < PD; i++) hpipe[i] <= hpipe[i-1];
   end
   assign core_hash_in = hpipe[PD-1];

   always @(posedge clk) cyc <= cyc + 1;

   // Job window: latched at edge e, terminated at edge e+len (next job or reset).
   // Issues happen at edges e+1 .. e+len-1, stopping after the all-ones nonce;
   // a hit on issue k is reported at edge e+k+PD+2 and survives only if that is before e+len;
   // exhaustion appears PD+2 edges after the all-ones issue.
   task automatic expect_job(input logic [NW-1:0] start, input logic [HW-1:0] target,
                             input logic [FW-1:0] fixed, input int len);
      logic [63:0] rem;
      int n;
      rem = 64'h1000_0000_0000_0000 - {4'h0, start};
      n = (rem < 64'(len - 1)) ? int'(rem) : len - 1;
      for (int k = 0; k < n; k++) cand_q.push_back({fixed, start + NW'(k)});
      for (int k = 0; k < n; k++) begin
         if (f(start + NW'(k)) == target) begin
            if (k <= len - PD - 3) gold_q.push_back(start + NW'(k));
            break;
         end
      end
      if (rem + 64'(PD + 2) < 64'(len)) exh_q.push_back(1'b1);
   endtask

   task automatic queues_empty(input string tag);
      check(cand_q.size() == 0, {tag, "_missing_issue"}, 192'(cand_q.size()), 192'(0));
      check(gold_q.size() == 0, {tag, "_missing_found"}, 192'(gold_q.size()), 192'(0));
      check(exh_q.size() == 0,  {tag, "_missing_exhausted"}, 192'(exh_q.size()), 192'(0));
   endtask

   task automatic check_idle(input string tag);
      check(core_valid == 1'b0, {tag, "_core_valid"}, 192'(core_valid), 192'(0));
      check(core_data == '0,    {tag, "_core_data"}, 192'(core_data), 192'(0));
      check(found == 1'b0,      {tag, "_found"}, 192'(found), 192'(0));
      check(golden == '0,       {tag, "_golden"}, 192'(golden), 192'(0));
      check(busy == 1'b0,       {tag, "_busy"}, 192'(busy), 192'(0));
      check(exhausted == 1'b0,  {tag, "_exhausted"}, 192'(exhausted), 192'(0));
   endtask

   // Called just after a negedge; new_work is sampled on the next rising edge.
   task automatic run_job(input logic [NW-1:0] start, input logic [HW-1:0] target, input int len);
      logic [FW-1:0] fx;
      fx = FW'({$urandom, $urandom});
      queues_empty("pre_job");
      expect_job(start, target, fx, len);
      tx_fixed_data  = fx;
      tx_target_hash = target;
      tx_start_nonce = start;
      tx_new_work    = 1'b1;
      @(negedge clk); #1;
      tx_new_work    = 1'b0;
      tx_fixed_data  = FW'({$urandom, $urandom});
      tx_target_hash = {5{$urandom}};
      tx_start_nonce = NW'({$urandom, $urandom});
      repeat (len - 1) @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      jt_reset = 1'b1;
      #1;
      check_idle({tag, "_async"});
      repeat (3) @(negedge clk);
      #1 jt_reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check_idle({tag, "_after"});
      queues_empty(tag);
   endtask

   logic          prev_found = 1'b0;
   logic [NW-1:0] prev_golden = '0;
   logic          prev_busy = 1'b0;
   logic          prev_exh = 1'b0;

   always @(negedge clk) begin
      if (jt_reset) begin
         prev_found  = 1'b0;
         prev_golden = '0;
         prev_busy   = 1'b0;
         prev_exh    = 1'b0;
      end else begin
         if (tx_new_work) begin
            check(!found && golden == '0, "latch_clear", 192'({found, golden}), 192'(0));
            check(busy && !exhausted && !core_valid, "latch_state",
                  192'({busy, exhausted, core_valid}), 192'(3'b100));
         end else if (prev_found) begin
            check(found && golden == prev_golden, "found_hold",
                  192'({found, golden}), 192'({1'b1, prev_golden}));
         end
         if (core_valid) begin
            if (cand_q.size() == 0) begin
               check(1'b0, "unexpected_issue", 192'(core_data), 192'(0));
            end else begin
               logic [FW+NW-1:0] e;
               e = cand_q.pop_front();
               check(core_data == e, "issue", 192'(core_data), 192'(e));
            end
            issue_cyc[core_data[NW-1:0]] = cyc;
            last_issue_cyc = cyc;
         end
         if (found && !prev_found) begin
            if (gold_q.size() == 0) begin
               check(1'b0, "unexpected_found", 192'(golden), 192'(0));
            end else begin
               logic [NW-1:0] g;
               int lat;
               g = gold_q.pop_front();
               check(golden == g, "golden", 192'(golden), 192'(g));
               lat = issue_cyc.exists(golden) ? cyc - issue_cyc[golden] : -1;
               check(lat == PD + 1, "found_latency", 192'(lat), 192'(PD + 1));
            end
         end
         if (exhausted && !prev_exh) begin
            if (exh_q.size() == 0) begin
               check(1'b0, "unexpected_exhausted", 192'(exhausted), 192'(0));
            end else begin
               void'(exh_q.pop_front());
               check(cyc - last_issue_cyc == PD + 2, "exhaust_latency",
                     192'(cyc - last_issue_cyc), 192'(PD + 2));
               check(prev_busy && !busy, "exhaust_busy", 192'({prev_busy, busy}), 192'(2'b10));
            end
         end
         prev_found  = found;
         prev_golden = golden;
         prev_busy   = busy;
         prev_exh    = exhausted;
      end
   end

   initial begin
      jt_reset       = 1'b1;
      tx_new_work    = 1'b0;
      tx_fixed_data  = '0;
      tx_target_hash = '0;
      tx_start_nonce = '0;
      #3;
      check_idle("reset_init");
      repeat (2) @(negedge clk);
      #1 jt_reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;

      // Basic search with a collision later in the range; found held for 100+ cycles.
      run_job(60'h100, f(60'h105), 120);
      run_job(60'h100, f(60'h107), 30);
      // Top of the nonce space: drain then exhausted, no wrap to 0.
      run_job(60'hFFF_FFFF_FFFF_FFFD, f(60'hFFF_FFFF_FFFF_FFFE), 20);
      // Restart two cycles before the report; next job shares the target, epoch must reject it.
      run_job(60'h100, f(60'h105), 9);
      run_job(60'h200, f(60'h105), 12);
      // Report edge coincides with new_work.
      run_job(60'h300, f(60'h305), 11);
      run_job(60'h400, f(60'h404), 25);

      for (int j = 0; j < 12; j++) begin
         logic [NW-1:0] s;
         int len, hk;
         len = $urandom_range(8, 40);
         s = NW'({$urandom, $urandom});
         if ($urandom_range(0, 2) == 0) s = 60'hFFF_FFFF_FFFF_FFFF - NW'($urandom_range(0, 40));
         hk = $urandom_range(0, len + 2);
         run_job(s, (j % 4 == 3) ? HW'({5{$urandom}}) : f(s + NW'(hk)), len);
      end

      // Reset mid-RUN, then recover with a fresh job and end with a reset.
      run_job(60'h500, f(60'h50A), 15);
      do_reset("reset_mid");
      run_job(60'h600, f(60'h602), 20);
      do_reset("reset_end");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
